impulse_applier: RTL and testbench

- Consumer of the OBB contact resolver output: takes one resolved contact (two impulse records plus body indices) per handshake and read-modify-writes both bodies' dynamic state in the body state RAM.
- Sits between the resolver and the body state memory, upstream of the integrator; one contact in flight at a time.
- Static bodies (inv_mass == 0) are never written.

---
 rtl/physics_pkg.sv | 64 ++++++
 rtl/body_state_update.sv | 31 +++
 rtl/impulse_applier.sv | 166 ++++++++++++++++
 tb/tb_impulse_applier.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/physics_pkg.sv
`default_nettype none
// ============================================================================
// Module      : physics_pkg
// Description : Shared types and helpers for the rigid-body physics pipeline.
//               It defines the body dynamic-state record, the per-body contact
//               impulse record, the applier FSM states and the saturation
//               helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package physics_pkg;

    localparam int BODY_DYN_W = 124;

    localparam logic [23:0] SAT24_MAX = 24'h7F_FFFF;
    localparam logic [23:0] SAT24_MIN = 24'h80_0000;
    localparam logic [10:0] SAT11_MAX = 11'h3FF;
    localparam logic [10:0] SAT11_MIN = 11'h400;

    // Field order is MSB first, so it matches the RAM word layout.
    typedef struct packed {
        logic [23:0] pos_x;
        logic [23:0] pos_y;
        logic [23:0] vel_x;
        logic [23:0] vel_y;
        logic [10:0] omega;
        logic [16:0] inv_mass;
    } body_dyn_t;

    typedef struct packed {
        logic [23:0] imp_x;
        logic [23:0] imp_y;
        logic [21:0] nudge_x;
        logic [21:0] nudge_y;
        logic [10:0] rot;
    } contact_impulse_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD1   = 3'd1,
        S_WAIT1 = 3'd2,
        S_WR1   = 3'd3,
        S_RD2   = 3'd4,
        S_WAIT2 = 3'd5,
        S_WR2   = 3'd6
    } applier_state_t;

    // Overflow exists only when the two top bits of the widened sum disagree.
    // In that case, the top bit gives the true sign of the result.
    function automatic logic [23:0] sat24(input logic [24:0] sum);
        if (sum[24] != sum[23]) begin
            return sum[24] ? SAT24_MIN : SAT24_MAX;
        end
        return sum[23:0];
    endfunction

    function automatic logic [10:0] sat11(input logic [11:0] sum);
        if (sum[11] != sum[10]) begin
            return sum[11] ? SAT11_MIN : SAT11_MAX;
        end
        return sum[10:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/body_state_update.sv
`default_nettype none
// ============================================================================
// Module      : body_state_update
// Description : Combinational update of one body's dynamic state by one
//               contact impulse record. All arithmetic saturates.
// Ports       : body_in  - current body state read from RAM
//               imp      - impulse / nudge / rotation for this body
//               body_out - updated state (inv_mass passed through)
// Revision    : 1.0 - initial release
// ============================================================================
module body_state_update
    import physics_pkg::*;
(
    input  body_dyn_t        body_in,
    input  contact_impulse_t imp,
    output body_dyn_t        body_out
);

    always_comb begin
        body_out       = body_in;
        // Each operand is sign-extended by one bit, so the sum cannot wrap
        // before it is saturated.
        body_out.vel_x = sat24({body_in.vel_x[23], body_in.vel_x} + {imp.imp_x[23], imp.imp_x});
        body_out.vel_y = sat24({body_in.vel_y[23], body_in.vel_y} + {imp.imp_y[23], imp.imp_y});
        body_out.pos_x = sat24({body_in.pos_x[23], body_in.pos_x} + {{3{imp.nudge_x[21]}}, imp.nudge_x});
        body_out.pos_y = sat24({body_in.pos_y[23], body_in.pos_y} + {{3{imp.nudge_y[21]}}, imp.nudge_y});
        body_out.omega = sat11({body_in.omega[10], body_in.omega} + {imp.rot[10], imp.rot});
    end

endmodule
`default_nettype wire

// File: rtl/impulse_applier.sv
`default_nettype none
// ============================================================================
// Module      : impulse_applier
// Description : Accepts one resolved contact per handshake and read-modify-
//               writes both bodies' dynamic state in the body state RAM.
//               Static bodies (inv_mass == 0) are read but never written.
// Ports       : in_*          - contact record with valid/ready handshake
//               mem_*         - body RAM port (1-cycle read latency)
//               applied_cnt   - contacts applied (wrapping)
//               dropped_cnt   - contacts dropped (wrapping)
//               busy          - a contact is in flight
// Revision    : 1.0 - initial release
// ============================================================================
module impulse_applier
    import physics_pkg::*;
#(
    parameter int N_BODIES = 16,
    parameter int IDX_W    = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IDX_W-1:0]      in_idx1,
    input  logic [IDX_W-1:0]      in_idx2,
    input  logic                  in_ignore,
    input  logic [23:0]           in_imp1_x,
    input  logic [23:0]           in_imp1_y,
    input  logic [23:0]           in_imp2_x,
    input  logic [23:0]           in_imp2_y,
    input  logic [21:0]           in_nudge1_x,
    input  logic [21:0]           in_nudge1_y,
    input  logic [21:0]           in_nudge2_x,
    input  logic [21:0]           in_nudge2_y,
    input  logic [10:0]           in_rot1,
    input  logic [10:0]           in_rot2,
    output logic                  mem_rd_en,
    output logic                  mem_wr_en,
    output logic [IDX_W-1:0]      mem_addr,
    input  logic [BODY_DYN_W-1:0] mem_rd_data,
    output logic [BODY_DYN_W-1:0] mem_wr_data,
    output logic [15:0]           applied_cnt,
    output logic [15:0]           dropped_cnt,
    output logic                  busy
);

    applier_state_t   r_state;
    applier_state_t   w_next;
    logic [IDX_W-1:0] r_idx1;
    logic [IDX_W-1:0] r_idx2;
    contact_impulse_t r_rec1;
    contact_impulse_t r_rec2;
    body_dyn_t        r_wr_data;
    logic [15:0]      r_applied;
    logic [15:0]      r_dropped;

    logic             w_transfer;
    logic             w_drop;
    logic             w_static;
    body_dyn_t        w_body_rd;
    body_dyn_t        w_body_upd;
    contact_impulse_t w_imp_sel;

    assign w_transfer = in_valid && (r_state == S_IDLE);

    // The index ports can be wider than the slot count, so a range check is needed.
    assign w_drop = in_ignore || (in_idx1 == in_idx2) ||
                    (int'(in_idx1) >= N_BODIES) || (int'(in_idx2) >= N_BODIES);

    assign w_body_rd = mem_rd_data;
    assign w_static  = (w_body_rd.inv_mass == 17'd0);

    // There is one shared updater. Side 2 is selected only while its read data is returning.
    assign w_imp_sel = (r_state == S_WAIT2) ? r_rec2 : r_rec1;

    body_state_update u_update (
        .body_in  (w_body_rd),
        .imp      (w_imp_sel),
        .body_out (w_body_upd)
    );

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        mem_addr  = '0;
        busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid && !w_drop) begin
                    w_next = S_RD1;
                end
            end
            S_RD1: begin
                mem_rd_en = 1'b1;
                mem_addr  = r_idx1;
                w_next    = S_WAIT1;
            end
            S_WAIT1: begin
                w_next = w_static ? S_RD2 : S_WR1;
            end
            S_WR1: begin
                mem_wr_en = 1'b1;
                mem_addr  = r_idx1;
                w_next    = S_RD2;
            end
            S_RD2: begin
                mem_rd_en = 1'b1;
                mem_addr  = r_idx2;
                w_next    = S_WAIT2;
            end
            S_WAIT2: begin
                w_next = w_static ? S_IDLE : S_WR2;
            end
            S_WR2: begin
                mem_wr_en = 1'b1;
                mem_addr  = r_idx2;
                w_next    = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_idx1    <= '0;
            r_idx2    <= '0;
            r_rec1    <= '0;
            r_rec2    <= '0;
            r_wr_data <= '0;
            r_applied <= '0;
            r_dropped <= '0;
        end else begin
            r_state <= w_next;
            if (w_transfer) begin
                r_idx1 <= in_idx1;
                r_idx2 <= in_idx2;
                r_rec1 <= '{imp_x: in_imp1_x, imp_y: in_imp1_y,
                            nudge_x: in_nudge1_x, nudge_y: in_nudge1_y, rot: in_rot1};
                r_rec2 <= '{imp_x: in_imp2_x, imp_y: in_imp2_y,
                            nudge_x: in_nudge2_x, nudge_y: in_nudge2_y, rot: in_rot2};
                if (w_drop) begin
                    r_dropped <= r_dropped + 16'd1;
                end
            end
            if ((r_state == S_WAIT1) || (r_state == S_WAIT2)) begin
                r_wr_data <= w_body_upd;
            end
            if ((r_state == S_WR2) || ((r_state == S_WAIT2) && w_static)) begin
                r_applied <= r_applied + 16'd1;
            end
        end
    end

    assign mem_wr_data = r_wr_data;
    assign applied_cnt = r_applied;
    assign dropped_cnt = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_impulse_applier.sv
`default_nettype none
// ============================================================================
// Module      : tb_impulse_applier
// Description : Directed self-checking bench for impulse_applier with a
//               behavioural body RAM (1-cycle read latency). The index width is
//               widened to 5 so an index of 16 is representable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_impulse_applier;
    import physics_pkg::*;

    localparam int N_BODIES = 16;
    localparam int IDX_W    = 5;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [IDX_W-1:0]      in_idx1, in_idx2;
    logic                  in_ignore;
    logic [23:0]           in_imp1_x, in_imp1_y, in_imp2_x, in_imp2_y;
    logic [21:0]           in_nudge1_x, in_nudge1_y, in_nudge2_x, in_nudge2_y;
    logic [10:0]           in_rot1, in_rot2;
    logic                  mem_rd_en, mem_wr_en;
    logic [IDX_W-1:0]      mem_addr;
    logic [BODY_DYN_W-1:0] mem_rd_data;
    logic [BODY_DYN_W-1:0] mem_wr_data;
    logic [15:0]           applied_cnt, dropped_cnt;
    logic                  busy;

    impulse_applier #(.N_BODIES(N_BODIES), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_idx1(in_idx1), .in_idx2(in_idx2), .in_ignore(in_ignore),
        .in_imp1_x(in_imp1_x), .in_imp1_y(in_imp1_y),
        .in_imp2_x(in_imp2_x), .in_imp2_y(in_imp2_y),
        .in_nudge1_x(in_nudge1_x), .in_nudge1_y(in_nudge1_y),
        .in_nudge2_x(in_nudge2_x), .in_nudge2_y(in_nudge2_y),
        .in_rot1(in_rot1), .in_rot2(in_rot2),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data), .mem_wr_data(mem_wr_data),
        .applied_cnt(applied_cnt), .dropped_cnt(dropped_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    // Body RAM. The bench preloads it through a side port while the DUT is idle.
    body_dyn_t        ram [0:(1<<IDX_W)-1];
    logic             tb_we = 1'b0;
    logic [IDX_W-1:0] tb_addr = '0;
    body_dyn_t        tb_data = '0;
    int               rd_pulses = 0;
    int               wr_pulses = 0;
    int               overlap   = 0;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= ram[mem_addr];
        if (mem_wr_en) ram[mem_addr] <= mem_wr_data;
        else if (tb_we) ram[tb_addr] <= tb_data;
        if (mem_rd_en) rd_pulses++;
        if (mem_wr_en) wr_pulses++;
        if (mem_rd_en && mem_wr_en) overlap++;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic body_dyn_t mk(input logic [23:0] px, input logic [23:0] py,
                                     input logic [23:0] vx, input logic [23:0] vy,
                                     input logic [10:0] om, input logic [16:0] im);
        return '{pos_x: px, pos_y: py, vel_x: vx, vel_y: vy, omega: om, inv_mass: im};
    endfunction

    task automatic load(input int idx, input body_dyn_t b);
        tb_we   = 1'b1;
        tb_addr = IDX_W'(idx);
        tb_data = b;
        @(posedge clk); #1;
        tb_we   = 1'b0;
    endtask

    task automatic clear_rec();
        in_ignore = 0;
        in_imp1_x = 0; in_imp1_y = 0; in_imp2_x = 0; in_imp2_y = 0;
        in_nudge1_x = 0; in_nudge1_y = 0; in_nudge2_x = 0; in_nudge2_y = 0;
        in_rot1 = 0; in_rot2 = 0;
    endtask

    // Present the record for one edge. The DUT is idle, so that edge is the transfer.
    task automatic send(input int i1, input int i2);
        in_idx1  = IDX_W'(i1);
        in_idx2  = IDX_W'(i2);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count cycles after the transfer edge until in_ready returns. The count is bounded.
    task automatic wait_ready(output int lat);
        lat = 0;
        while (!in_ready && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    int lat, rd0, wr0;

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_idx1 = '0; in_idx2 = '0;
        clear_rec();
        for (int i = 0; i < (1<<IDX_W); i++) ram[i] = '0;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_wr_en", mem_wr_en, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wr_data", mem_wr_data, 0);
        chk("rst_applied", applied_cnt, 0);
        chk("rst_dropped", dropped_cnt, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Nominal contact between two dynamic bodies
        load(1, mk(24'h0, 24'h0, 24'h000100, 24'h0, 11'h0, 17'h00400));
        load(2, mk(24'h0, 24'h0, 24'h000000, 24'h0, 11'h0, 17'h00400));
        wr0 = wr_pulses;
        clear_rec();
        in_imp1_x = 24'h000040; in_imp2_x = 24'hFFFFC0;
        send(1, 2);
        chk("nom_busy", busy, 1);
        wait_ready(lat);
        chk("nom_latency", lat, 6);
        chk("nom_body1", ram[1], mk(24'h0, 24'h0, 24'h000140, 24'h0, 11'h0, 17'h00400));
        chk("nom_body2_vx", ram[2].vel_x, 24'hFFFFC0);
        chk("nom_applied", applied_cnt, 1);
        chk("nom_wr_pulses", wr_pulses - wr0, 2);

        // Drop because the ignore flag is set
        rd0 = rd_pulses; wr0 = wr_pulses;
        clear_rec(); in_ignore = 1;
        send(1, 2);
        chk("ign_in_ready", in_ready, 1);
        @(posedge clk); #1;
        chk("ign_mem_traffic", (rd_pulses - rd0) + (wr_pulses - wr0), 0);
        chk("ign_dropped", dropped_cnt, 1);

        // Drop because both indices are the same, then because an index is out of range
        load(3, mk(24'h11, 24'h22, 24'h33, 24'h44, 11'h55, 17'h66));
        rd0 = rd_pulses; wr0 = wr_pulses;
        clear_rec(); in_imp1_x = 24'h1; in_imp2_x = 24'h1;
        send(3, 3);
        chk("same_in_ready", in_ready, 1);
        send(16, 2);
        chk("oor_in_ready", in_ready, 1);
        @(posedge clk); #1;
        chk("drop_mem_traffic", (rd_pulses - rd0) + (wr_pulses - wr0), 0);
        chk("drop_dropped", dropped_cnt, 3);
        chk("drop_ram3", ram[3], mk(24'h11, 24'h22, 24'h33, 24'h44, 11'h55, 17'h66));
        chk("drop_applied", applied_cnt, 1);

        // Body 2 is static, so only body 1 is written
        load(4, mk(24'h0, 24'h0, 24'h0, 24'h0, 11'h0, 17'h00400));
        load(5, mk(24'h0, 24'h0, 24'h0, 24'h0, 11'h0, 17'h00000));
        wr0 = wr_pulses;
        clear_rec(); in_imp1_x = 24'h000010; in_nudge2_x = 22'h000100;
        send(4, 5);
        wait_ready(lat);
        chk("stat_latency", lat, 5);
        chk("stat_wr_pulses", wr_pulses - wr0, 1);
        chk("stat_body5", ram[5], mk(24'h0, 24'h0, 24'h0, 24'h0, 11'h0, 17'h0));
        chk("stat_body4_vx", ram[4].vel_x, 24'h000010);
        chk("stat_applied", applied_cnt, 2);

        // Both bodies are static
        load(6, mk(24'h0, 24'h0, 24'h0, 24'h0, 11'h0, 17'h00000));
        wr0 = wr_pulses;
        clear_rec(); in_nudge1_x = 22'h000100; in_nudge2_x = 22'h000100;
        send(5, 6);
        wait_ready(lat);
        chk("stat2_latency", lat, 4);
        chk("stat2_wr_pulses", wr_pulses - wr0, 0);
        chk("stat2_applied", applied_cnt, 3);

        // Saturation in both directions and a non-saturating negative nudge
        load(7, mk(24'h000000, 24'h800010, 24'h7FFF00, 24'h000000, 11'h400, 17'h00001));
        load(8, mk(24'h7FFFF0, 24'h000050, 24'h000000, 24'h800005, 11'h3F0, 17'h00002));
        clear_rec();
        in_imp1_x = 24'h000200; in_rot1 = 11'h7FF; in_nudge1_y = 22'h3FFF00;
        in_nudge2_x = 22'h000100; in_nudge2_y = 22'h3FFFF0;
        in_imp2_y = 24'hFFFFF0; in_rot2 = 11'h020;
        send(7, 8);
        wait_ready(lat);
        chk("sat_latency", lat, 6);
        chk("sat_body7", ram[7], mk(24'h000000, 24'h800000, 24'h7FFFFF, 24'h000000, 11'h400, 17'h00001));
        chk("sat_body8", ram[8], mk(24'h7FFFFF, 24'h000040, 24'h000000, 24'h800000, 11'h3FF, 17'h00002));
        chk("sat_applied", applied_cnt, 4);

        // Reset during WR1 aborts the contact without writing
        load(9,  mk(24'h0, 24'h0, 24'h000100, 24'h0, 11'h0, 17'h00400));
        load(10, mk(24'h0, 24'h0, 24'h000200, 24'h0, 11'h0, 17'h00400));
        clear_rec(); in_imp1_x = 24'h000001; in_imp2_x = 24'h000002;
        send(9, 10);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_in_wr1", mem_wr_en, 1);
        wr0 = wr_pulses;
        reset_n = 1'b0;
        #1;
        chk("mid_wr_en", mem_wr_en, 0);
        chk("mid_in_ready", in_ready, 1);
        chk("mid_busy", busy, 0);
        chk("mid_addr", mem_addr, 0);
        chk("mid_wr_data", mem_wr_data, 0);
        chk("mid_counters", {applied_cnt, dropped_cnt}, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_no_write", wr_pulses - wr0, 0);
        chk("mid_ram9", ram[9].vel_x, 24'h000100);
        reset_n = 1'b1;
        @(posedge clk); #1;
        send(9, 10);
        wait_ready(lat);
        chk("post_latency", lat, 6);
        chk("post_body9_vx", ram[9].vel_x, 24'h000101);
        chk("post_body10_vx", ram[10].vel_x, 24'h000202);
        chk("post_applied", applied_cnt, 1);
        chk("strobe_overlap", overlap, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
